// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral receive path: default bus width,
// packer state encoding and a constant-evaluable ceil(log2) helper.
package periph_pkg;

    localparam int DATA_W_DEFAULT = 3;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/periph_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and a registered
// occupancy count from which full/empty are derived.
module periph_sync_fifo
    import periph_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic                   clk1,
    input  logic                   rst1,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [clog2(DEPTH):0]  level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW    = clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // NOTE: storage is deliberately not reset; the pointers and level define which entries are live.
    always_ff @(posedge clk1) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/periph_rx_packer.sv
// Receive buffer: queues words from the peripheral handshake and packs PACK
// of them into one wide word, offered to the consumer under valid/ready.
module periph_rx_packer
    import periph_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int PACK   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                        clk1,
    input  logic                        rst1,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W*PACK-1:0]      out_data,
    output logic [clog2(PACK+1)-1:0]    out_count,
    output logic [clog2(DEPTH):0]       level,
    output logic                        overflow
);

    localparam int CW = clog2(PACK + 1);

    logic [0:0]        state;
    logic [CW-1:0]     idx;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Full comes from the registered level, so a same-cycle pop never frees a slot early.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_FILL) && !empty;

    periph_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst1  (rst1),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // NOTE: all state here uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk1) begin
        if (!rst1) begin
            state     <= ST_FILL;
            idx       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_valid && !in_ready) overflow <= 1'b1;

            if (state == ST_FILL) begin
                if (!empty) begin
                    out_data[idx*DATA_W +: DATA_W] <= head;
                    if (idx == CW'(PACK - 1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_count <= CW'(PACK);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else if (flush && idx != '0) begin
                    // Unused lanes are already zero: the pack register is cleared on every hand-off.
                    state     <= ST_HOLD;
                    out_valid <= 1'b1;
                    out_count <= idx;
                end
            end else if (out_ready) begin
                state     <= ST_FILL;
                idx       <= '0;
                out_data  <= '0;
                out_count <= '0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/periph_rx_packer.md
Name: periph_rx_packer

Overview:
Receive-side buffer in the peripheral clock domain, directly downstream of the peripheral handshake FSM. Each 3-bit word the peripheral accepts from the CPU is pushed here, queued in a small synchronous FIFO, and packed PACK words at a time into a wide word for the next consumer, under a valid/ready handshake. in_ready gives the peripheral a backpressure signal; it withholds ack while in_ready=0.

Parameters:
DATA_W, 3, width of one transferred word; matches the CPU↔peripheral data bus.
PACK, 4, number of words per packed output word.
DEPTH, 8, FIFO depth in words; power of 2, ≥2.

Ports:
clk1  in  1  peripheral clock; the single clock of this block.
rst1  in  1  synchronous, active-low reset, sampled on the rising edge of clk1.
in_valid  in  1  one-cycle push strobe from the peripheral.
in_data  in  DATA_W  word to push.
in_ready  out  1  FIFO not full; registered.
flush  in  1  emit a partially filled packed word.
out_valid  out  1  out_data/out_count valid.
out_ready  in  1  consumer accepts the word when high together with out_valid.
out_data  out  DATA_W*PACK  packed word; word 0 in the LSBs.
out_count  out  clog2(PACK+1)  number of valid words in out_data.
level  out  clog2(DEPTH)+1  FIFO occupancy.
overflow  out  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (rst1=0 at a clk1 edge): out_valid=0, out_data=0, out_count=0, level=0, in_ready=1, overflow=0, FSM=FILL, pack index=0. Reset mid-operation discards all queued and partially packed words.
- Push: when in_valid=1 and in_ready=1, write at wptr, wptr+1 mod DEPTH. in_valid=1 with in_ready=0: word dropped, overflow←1, held until reset.
- in_ready is computed from registered occupancy. It is not raised early by a same-cycle pop, so a full FIFO refuses a push even if a pop occurs in that cycle.
- The FIFO read is first-word-fall-through (head combinationally visible). level updates the cycle after a push or pop; a simultaneous push and pop leaves level unchanged.
- Packer FSM:
  - FILL: if FIFO non-empty, pop one word per cycle into bits [idx*DATA_W +: DATA_W], idx+1.
    - When the PACK-th word is popped → HOLD, out_valid=1, out_count=PACK.
    - If FIFO empty, flush=1 and idx>0 → HOLD, out_count=idx, unused bits 0.
    - flush with idx=0 is ignored.
    - flush with FIFO non-empty is ignored; FILL keeps popping.
  - HOLD: out_data/out_count/out_valid stable. No pops. On out_ready=1 → FILL, idx=0, pack register cleared, out_valid=0 next cycle.
- Latency: a word pushed in cycle t can be popped at t+1. With PACK words pushed back-to-back in cycles 0..PACK-1, out_valid rises at the edge ending cycle PACK (visible in cycle PACK+1).
- Throughput: one word per cycle in FILL, plus one HOLD cycle per packed word minimum.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH inclusive.

Decomposition:
- Shared package periph_pkg: DATA_W default; state encoding FILL/HOLD; clog2 helper.
- Sub-module periph_sync_fifo:
  - clk1/rst1, push/pop, data, level, full/empty.
  - Instantiated once.
  - The packer FSM and overflow flag stay in the top module.

Test Plan:
Run all scenarios with DATA_W=3, PACK=4, DEPTH=8.
1. Reset: hold rst1=0 for 2 edges with in_valid=1 → out_valid=0, in_ready=1, level=0, overflow=0, out_data=0; nothing stored afterwards.
2. Basic pack: push 1,2,3,4 in consecutive cycles with out_ready=1 → single out_valid cycle, out_data=12'h8D1, out_count=4, level returns to 0.
3. Backpressure and overflow:
   - With out_ready=0, push words 0..7,0..3 (12 words) → first four held in HOLD, level=8, in_ready=0.
   - A 13th push → overflow=1 and the word is dropped.
   - Then out_ready=1 → three packed words in order, 12'h688 / 12'hFAC / 12'h688; overflow stays 1.
4. Flush: push 5,6, wait 2 cycles, pulse flush → out_valid, out_count=2, out_data=12'h035. flush with an empty packer → no output.
5. Reset mid-operation: push 7,7, then rst1=0 for one edge, then push 1,2,3,4 → only one output word, 12'h8D1.
6. Wrap/stream: push 20 words (pattern i mod 8) with out_ready toggling every cycle → 5 packed words in order, no loss, overflow=0, pointers wrapped ≥2 times.
